mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// Arbiter sharing one memory between the core's memory port and an external requester.
// Bounded wait for the external side, and a hung memory ends the access with an error.
module mem_port_arbiter #(
  parameter int MAX_CPU_STREAK = 4,
  parameter int TIMEOUT        = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  output logic [31:0] ext_rdata,
  output logic        ext_ack,
  output logic        ext_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int SW = $clog2(MAX_CPU_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_CPU_STREAK);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic          r_owner;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [SW-1:0] r_streak;
  logic [TW-1:0] r_tmo;
  logic [31:0]   r_rdata;
  logic          r_err;

  logic w_grant_any;
  logic w_grant_ext;
  logic w_busy;
  logic w_done;

  assign w_grant_any = cpu_req | ext_req;
  // ext wins a tie only once the cpu has used up its streak allowance
  assign w_grant_ext = ext_req & (~cpu_req | (r_streak == STREAK_MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_owner  <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_streak <= '0;
      r_tmo    <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_any) begin
            r_state  <= S_BUSY;
            r_owner  <= w_grant_ext;
            r_we     <= w_grant_ext ? ext_we    : cpu_we;
            r_addr   <= w_grant_ext ? ext_addr  : cpu_addr;
            r_wdata  <= w_grant_ext ? ext_wdata : cpu_wdata;
            r_tmo    <= '0;
            r_streak <= (!w_grant_ext && ext_req) ? r_streak + SW'(1) : '0;
          end
        end
        S_BUSY: begin
          // a ready on the threshold cycle still completes normally
          if (mem_ready) begin
            r_rdata <= r_we ? 32'd0 : mem_rdata;
            r_err   <= 1'b0;
            r_state <= S_DONE;
          end else if (r_tmo == TMO_LAST) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_tmo   <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_busy = (r_state == S_BUSY);
  assign w_done = (r_state == S_DONE);

  assign mem_en    = w_busy;
  assign mem_we    = w_busy & r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  assign cpu_ack   = w_done & ~r_owner;
  assign cpu_err   = cpu_ack & r_err;
  assign cpu_rdata = cpu_ack ? r_rdata : 32'd0;
  assign ext_ack   = w_done & r_owner;
  assign ext_err   = ext_ack & r_err;
  assign ext_rdata = ext_ack ? r_rdata : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_port_arbiter: directed vector table, corner sequences, and a
// randomized transaction run scored against a per-access arbitration model.
module tb_mem_port_arbiter;
  localparam int MAXS = 4;
  localparam int TMO  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, ext_req, ext_we;
  logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic [31:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_ack, cpu_err, ext_ack, ext_err, mem_en, mem_we, mem_ready;

  mem_port_arbiter #(.MAX_CPU_STREAK(MAXS), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack), .ext_err(ext_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wait_c;
    logic [31:0] mem_val;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  // requester-side intent and model state
  bit          cpu_pend, ext_pend;
  logic        cpu_we_t, ext_we_t;
  logic [31:0] cpu_addr_t, cpu_wdata_t, ext_addr_t, ext_wdata_t;
  int          m_streak;
  logic [31:0] ref_mem [0:15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, wanted %h", name, act, exp);
  endtask

  task automatic apply_reqs();
    cpu_req = cpu_pend; cpu_we = cpu_we_t; cpu_addr = cpu_addr_t; cpu_wdata = cpu_wdata_t;
    ext_req = ext_pend; ext_we = ext_we_t; ext_addr = ext_addr_t; ext_wdata = ext_wdata_t;
  endtask

  task automatic new_txn(input bit p);
    if (!p) begin
      cpu_pend = 1'b1; cpu_we_t = 1'($urandom);
      cpu_addr_t = $urandom & 32'hFFFF_FFFC; cpu_wdata_t = $urandom;
    end else begin
      ext_pend = 1'b1; ext_we_t = 1'($urandom);
      ext_addr_t = $urandom & 32'hFFFF_FFFC; ext_wdata_t = $urandom;
    end
  endtask

  task automatic step();
    @(posedge clk); @(negedge clk);
  endtask

  // Entered at the negedge of an idle cycle with requests applied; returns at the
  // negedge of the ack cycle. wait_c = BUSY cycles before mem_ready is raised.
  task automatic serve(input int wait_c, input logic [31:0] rd_val, input bit use_mem,
                       output bit who, output logic [31:0] act_rd, output logic act_err);
    bit          ew, eerr;
    logic        ewe;
    logic [31:0] eaddr, ewd, erd;
    int          nb;
    chk("idle_mem_en", {mem_en, mem_we}, 0);
    chk("idle_no_ack", {cpu_ack, ext_ack, cpu_err, ext_err}, 0);
    mem_ready = 1'($urandom);
    mem_rdata = $urandom;
    if (cpu_pend && ext_pend) ew = (m_streak == MAXS);
    else ew = !cpu_pend;
    m_streak = (!ew && ext_pend) ? m_streak + 1 : 0;
    ewe   = ew ? ext_we_t    : cpu_we_t;
    eaddr = ew ? ext_addr_t  : cpu_addr_t;
    ewd   = ew ? ext_wdata_t : cpu_wdata_t;
    eerr  = (wait_c > TMO);
    nb    = eerr ? TMO + 1 : wait_c + 1;
    erd   = (ewe || eerr) ? 32'd0 : (use_mem ? ref_mem[eaddr[5:2]] : rd_val);
    step();
    for (int bc = 0; bc < nb; bc++) begin
      chk("busy_mem_en", mem_en, 1);
      chk("busy_mem_we", mem_we, ewe);
      chk("busy_mem_addr", mem_addr, eaddr);
      chk("busy_mem_wdata", mem_wdata, ewd);
      chk("busy_no_ack", {cpu_ack, ext_ack, cpu_err, ext_err}, 0);
      cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
      ext_we = 1'($urandom); ext_addr = $urandom; ext_wdata = $urandom;
      if (ew) cpu_req = 1'($urandom); else ext_req = 1'($urandom);
      mem_ready = (bc == wait_c);
      mem_rdata = mem_ready ? (use_mem ? ref_mem[mem_addr[5:2]] : rd_val) : $urandom;
      step();
    end
    mem_ready = 1'($urandom);
    who     = ext_ack;
    act_rd  = ew ? ext_rdata : cpu_rdata;
    act_err = ew ? ext_err : cpu_err;
    chk(ew ? "ext_ack" : "cpu_ack", ew ? ext_ack : cpu_ack, 1);
    chk("other_ack_err", ew ? {cpu_ack, cpu_err} : {ext_ack, ext_err}, 0);
    chk("ack_rdata", act_rd, erd);
    chk("ack_err", act_err, eerr);
    chk("done_mem_en", {mem_en, mem_we}, 0);
    if (use_mem && ewe && !eerr) ref_mem[eaddr[5:2]] = ewd;
    if (ew) ext_pend = 1'b0; else cpu_pend = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [6];
    bit          who;
    logic [31:0] rd;
    logic        er;
    logic [9:0]  seq;
    int          w;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,          0,  32'hE3A0_0005, 32'hE3A0_0005, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678, 3,  32'hFFFF_FFFF, 32'h0,         1'b0};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_0008, 32'hAAAA_5555, 1,  32'h1111_2222, 32'h0,         1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,          2,  32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,          TMO, 32'h0BAD_BEEF, 32'h0BAD_BEEF, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_0024, 32'h0,          40, 32'h7777_7777, 32'h0,         1'b1};

    for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
    cpu_pend = 0; ext_pend = 0; m_streak = 0;
    cpu_we_t = 0; cpu_addr_t = 0; cpu_wdata_t = 0;
    ext_we_t = 0; ext_addr_t = 0; ext_wdata_t = 0;
    apply_reqs();
    mem_ready = 0; mem_rdata = 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mem", {mem_en, mem_we}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_acks", {cpu_ack, cpu_err, ext_ack, ext_err}, 0);
    chk("rst_rdata", cpu_rdata | ext_rdata, 0);
    reset = 1'b0;

    // directed single-requester table
    foreach (vecs[i]) begin
      if (!vecs[i].port) begin
        cpu_pend = 1; cpu_we_t = vecs[i].we; cpu_addr_t = vecs[i].addr; cpu_wdata_t = vecs[i].wdata;
      end else begin
        ext_pend = 1; ext_we_t = vecs[i].we; ext_addr_t = vecs[i].addr; ext_wdata_t = vecs[i].wdata;
      end
      apply_reqs();
      serve(vecs[i].wait_c, vecs[i].mem_val, 1'b0, who, rd, er);
      chk("vec_owner", who, vecs[i].port);
      chk("vec_rdata", rd, vecs[i].exp_rdata);
      chk("vec_err", er, vecs[i].exp_err);
      apply_reqs();
      step();
    end

    // timeout on cpu while ext waits, then ext served normally
    cpu_pend = 1; cpu_we_t = 0; cpu_addr_t = 32'h0000_0030; cpu_wdata_t = 0;
    ext_pend = 1; ext_we_t = 1; ext_addr_t = 32'h0000_0080; ext_wdata_t = 32'h5555_AAAA;
    apply_reqs();
    serve(100, 32'h0, 1'b0, who, rd, er);
    chk("tmo_owner", who, 0);
    chk("tmo_err", er, 1);
    apply_reqs();
    step();
    serve(0, 32'h0, 1'b0, who, rd, er);
    chk("after_tmo_owner", who, 1);
    chk("after_tmo_err", er, 0);
    apply_reqs();
    step();

    // both requesting continuously: streak-limited grant pattern
    cpu_pend = 1; cpu_we_t = 0; cpu_addr_t = 32'h0000_0100; cpu_wdata_t = 0;
    ext_pend = 1; ext_we_t = 1; ext_addr_t = 32'h0000_0200; ext_wdata_t = 32'h0BEE_F00D;
    apply_reqs();
    for (int g = 0; g < 10; g++) begin
      serve(g % 2, 32'h1000 + g, 1'b0, who, rd, er);
      seq[g] = who;
      new_txn(who);
      apply_reqs();
      step();
    end
    chk("streak_seq", seq, 10'b10_0001_0000);
    cpu_pend = 0; ext_pend = 0;
    apply_reqs();
    step();

    // randomized traffic against the reference memory
    for (int it = 0; it < 150; it++) begin
      if (!cpu_pend && !ext_pend) begin
        new_txn(1'($urandom));
        apply_reqs();
      end
      w = ($urandom_range(15) == 0) ? TMO + 1 + $urandom_range(2) : $urandom_range(3);
      serve(w, 32'h0, 1'b1, who, rd, er);
      if (!cpu_pend && $urandom_range(1) == 1) new_txn(1'b0);
      if (!ext_pend && $urandom_range(1) == 1) new_txn(1'b1);
      apply_reqs();
      step();
    end
    cpu_pend = 0; ext_pend = 0;
    apply_reqs();
    step();

    // asynchronous reset in the middle of a write access
    cpu_pend = 1; cpu_we_t = 1; cpu_addr_t = 32'h0000_0F00; cpu_wdata_t = 32'hDEAD_BEEF;
    apply_reqs();
    step();
    chk("pre_rst_busy", {mem_en, mem_we}, 2'b11);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_mem", {mem_en, mem_we}, 0);
    chk("async_rst_addr", mem_addr, 0);
    chk("async_rst_wdata", mem_wdata, 0);
    chk("async_rst_acks", {cpu_ack, ext_ack, cpu_err, ext_err}, 0);
    cpu_pend = 0;
    apply_reqs();
    mem_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("in_rst_no_ack", {cpu_ack, mem_en}, 0);
    reset = 1'b0;
    m_streak = 0;
    step();
    chk("post_rst_no_ack", {cpu_ack, ext_ack, mem_en}, 0);
    mem_ready = 0;
    cpu_pend = 1; cpu_we_t = 0; cpu_addr_t = 32'h0000_0010; cpu_wdata_t = 0;
    apply_reqs();
    serve(0, 32'h5A5A_0001, 1'b0, who, rd, er);
    chk("post_rst_owner", who, 0);
    chk("post_rst_rdata", rd, 32'h5A5A_0001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
